mul_scheduler: RTL and testbench

MUL_SCHEDULER -- requirements
Module: mul_scheduler

---
 rtl/mul_scheduler.sv | 157 +++++++++++++++
 tb/tb_mul_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_scheduler.sv
`timescale 1ns/1ps
// mul_scheduler: two-requester round-robin front end for a fixed-latency,
// non-stallable floating-point multiplier, with a result FIFO feeding a
// valid/ready writeback port. Issue credit counts in-flight operations plus
// buffered results, so a returning result always has a FIFO slot.
// Optional feature: define MUL_SCHED_SCOREBOARD_EN to block requests whose
// destination tag still has a pending writeback (busy_mask tracking).
module mul_scheduler #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] op0_a,
    input  logic [31:0] op0_b,
    input  logic [31:0] op1_a,
    input  logic [31:0] op1_b,
    input  logic [3:0]  dest0,
    input  logic [3:0]  dest1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        mulEna,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [3:0]  in_dest,
    input  logic        done,
    input  logic [31:0] result,
    input  logic [3:0]  out_dest,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_dest,
    input  logic        wb_ready,
    output logic [15:0] busy_mask
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    logic              r_rr_ptr;     // 0: requester 0 preferred
    logic [CW-1:0]     r_inflight;   // operations inside the multiplier
    logic [CW-1:0]     r_count;      // FIFO occupancy
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [35:0]       r_mem [FIFO_DEPTH];
    logic [31:0]       r_op1;
    logic [31:0]       r_op2;
    logic [3:0]        r_dest;

    logic              w_pop;
    logic              w_push;
    logic              w_grant;
    logic              w_credit;
    logic [CW:0]       w_outstanding;
    logic              w_blk0;
    logic              w_blk1;
    logic              w_elig0;
    logic              w_elig1;
    logic [35:0]       w_head;

    assign wb_valid      = (r_count != '0);
    assign w_pop         = wb_valid & wb_ready;
    // A done with nothing in flight is a leftover from before reset.
    assign w_push        = done & (r_inflight != '0);
    assign w_outstanding = {1'b0, r_inflight} + {1'b0, r_count};
    // A pop in the same cycle frees a slot, so a full pipeline can still issue.
    assign w_credit      = (w_outstanding < DEPTH_V) | w_pop;
    assign w_head        = r_mem[r_rd_ptr];
    assign wb_data       = wb_valid ? w_head[31:0]  : 32'd0;
    assign wb_dest       = wb_valid ? w_head[35:32] : 4'd0;

`ifdef MUL_SCHED_SCOREBOARD_EN
    logic [15:0] r_busy;
    assign w_blk0    = r_busy[dest0];
    assign w_blk1    = r_busy[dest1];
    assign busy_mask = r_busy;

    // Pending-write flags: clear on the popped tag, then set the granted tag (set wins).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~(w_pop ? (16'd1 << wb_dest) : 16'd0))
                      | (w_grant ? (16'd1 << in_dest) : 16'd0);
        end
    end
`else
    assign w_blk0    = 1'b0;
    assign w_blk1    = 1'b0;
    assign busy_mask = 16'd0;
`endif

    // nrst gates eligibility so grants drop the instant reset asserts.
    assign w_elig0 = nrst & req0 & w_credit & ~w_blk0;
    assign w_elig1 = nrst & req1 & w_credit & ~w_blk1;
    assign w_grant = gnt0 | gnt1;

    // Round-robin arbitration and combinational issue to the multiplier.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        mulEna   = 1'b0;
        operand1 = r_op1;
        operand2 = r_op2;
        in_dest  = r_dest;
        if (w_elig0 && w_elig1) begin
            gnt0 = ~r_rr_ptr;
            gnt1 = r_rr_ptr;
        end else begin
            gnt0 = w_elig0;
            gnt1 = w_elig1;
        end
        if (gnt0) begin
            mulEna   = 1'b1;
            operand1 = op0_a;
            operand2 = op0_b;
            in_dest  = dest0;
        end else if (gnt1) begin
            mulEna   = 1'b1;
            operand1 = op1_a;
            operand2 = op1_b;
            in_dest  = dest1;
        end
    end

    // Control state: arbitration pointer, credit counters, FIFO pointers, held operands.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rr_ptr   <= 1'b0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_dest     <= '0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= gnt0;
                r_op1    <= operand1;
                r_op2    <= operand2;
                r_dest   <= in_dest;
            end
            r_inflight <= r_inflight + CW'(w_grant) - CW'(w_push);
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Result storage; contents only become visible through the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {out_dest, result};
    end

endmodule

// File: tb/tb_mul_scheduler.sv
`timescale 1ns/1ps
// Bench for mul_scheduler: behavioural multiplier, result scoreboard queue,
// a table of single-operation vectors plus hand-built arbitration, credit,
// scoreboard and reset sequences.
module tb_mul_scheduler;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req0, req1;
    logic [31:0] op0_a, op0_b, op1_a, op1_b;
    logic [3:0]  dest0, dest1;
    logic        gnt0, gnt1, mulEna;
    logic [31:0] operand1, operand2;
    logic [3:0]  in_dest;
    logic        done;
    logic [31:0] result;
    logic [3:0]  out_dest;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [3:0]  wb_dest;
    logic        wb_ready;
    logic [15:0] busy_mask;

    always #5 clk = ~clk;

    mul_scheduler #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .nrst(nrst), .req0(req0), .req1(req1),
        .op0_a(op0_a), .op0_b(op0_b), .op1_a(op1_a), .op1_b(op1_b),
        .dest0(dest0), .dest1(dest1), .gnt0(gnt0), .gnt1(gnt1),
        .mulEna(mulEna), .operand1(operand1), .operand2(operand2), .in_dest(in_dest),
        .done(done), .result(result), .out_dest(out_dest),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest), .wb_ready(wb_ready),
        .busy_mask(busy_mask)
    );

    // Exact-case single-precision multiply (normal operands, zero; truncating).
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (m[47]) begin
            e = e + 10'd1;
            return {s, e[7:0], m[46:24]};
        end
        return {s, e[7:0], m[45:23]};
    endfunction

    // Multiplier model: mulEna sampled on one edge, done presented so that the
    // result is captured by the scheduler on the fourth edge counting that one.
    localparam int LAT = 3;
    logic        mv [LAT];
    logic [3:0]  md [LAT];
    logic [31:0] mr [LAT];
    always @(posedge clk) begin
        mv[0] <= mulEna;
        md[0] <= in_dest;
        mr[0] <= fmul(operand1, operand2);
        for (int i = 1; i < LAT; i++) begin
            mv[i] <= mv[i-1];
            md[i] <= md[i-1];
            mr[i] <= mr[i-1];
        end
    end
    assign done     = mv[LAT-1];
    assign result   = mr[LAT-1];
    assign out_dest = md[LAT-1];

    int          errs   = 0;
    int          checks = 0;
    int          ngnt   = 0;
    logic [35:0] sbq [$];
    int          glog [$];
    logic [31:0] exp0, exp1;
    logic        sg0, sg1, swv;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: issue checks, scoreboard push on grant, pop/compare on writeback.
    logic        pv;
    logic [35:0] pd;
    always @(negedge clk) begin
        if (!nrst) begin
            pv = 1'b0;
        end else begin
            chk("mulEna", mulEna, gnt0 | gnt1);
            if (gnt0 || gnt1) chk("gnt_onehot", gnt0 & gnt1, 0);
            if (gnt0) begin
                chk("gnt0_req", req0, 1);
                chk("issue0", {in_dest, operand1, operand2}, {dest0, op0_a, op0_b});
                sbq.push_back({dest0, exp0});
                glog.push_back(0);
                ngnt++;
            end else if (gnt1) begin
                chk("gnt1_req", req1, 1);
                chk("issue1", {in_dest, operand1, operand2}, {dest1, op1_a, op1_b});
                sbq.push_back({dest1, exp1});
                glog.push_back(1);
                ngnt++;
            end
            if (pv) chk("wb_hold", {wb_valid, wb_dest, wb_data}, {1'b1, pd});
            if (wb_valid && wb_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL wb_unexpected: got dest %0d data 0x%0h with nothing expected", wb_dest, wb_data);
                end else begin
                    chk("wb_result", {wb_dest, wb_data}, sbq.pop_front());
                end
            end
            pv = wb_valid && !wb_ready;
            pd = {wb_dest, wb_data};
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One cycle: sample grants before the edge, advance tags of granted requesters.
    task automatic step();
        @(negedge clk);
        sg0 = gnt0;
        sg1 = gnt1;
        swv = wb_valid;
        @(posedge clk);
        #1;
        if (sg0) dest0 = dest0 + 4'd2;
        if (sg1) dest1 = dest1 + 4'd2;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        wb_ready = 1'b1;
        while ((sbq.size() != 0 || wb_valid) && n < 60) begin
            cyc();
            n++;
        end
        chk({nm, "_drain"}, n < 60, 1);
    endtask

    typedef struct {
        logic        who;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  d;
        logic [31:0] p;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv [6];
        int   n, k, base;
        logic seen, popped;

        tv[0] = '{1'b0, 32'h3FC00000, 32'h40000000, 4'd3,  32'h40400000}; // 1.5*2
        tv[1] = '{1'b0, 32'h40000000, 32'h40000000, 4'd7,  32'h40800000}; // 2*2, lone req vs pointer
        tv[2] = '{1'b1, 32'h40400000, 32'h3F000000, 4'd0,  32'h3FC00000}; // 3*0.5
        tv[3] = '{1'b1, 32'hBF800000, 32'h40000000, 4'd15, 32'hC0000000}; // -1*2
        tv[4] = '{1'b0, 32'h3FC00000, 32'h3FC00000, 4'd9,  32'h40100000}; // 1.5*1.5
        tv[5] = '{1'b1, 32'h00000000, 32'h40A00000, 4'd1,  32'h00000000}; // 0*5

        nrst = 1'b0; req0 = 1'b0; req1 = 1'b0; wb_ready = 1'b0;
        op0_a = '0; op0_b = '0; op1_a = '0; op1_b = '0;
        dest0 = '0; dest1 = '0; exp0 = '0; exp1 = '0;
        repeat (2) cyc();

        // Reset state, including grant suppression with a live request.
        req0 = 1'b1;
        #1;
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_outputs", {mulEna, wb_valid, busy_mask, in_dest, wb_dest, wb_data},  0);
        chk("rst_operands", {operand1, operand2}, 0);
        req0 = 1'b0;
        nrst = 1'b1;
        cyc();

        // Table of single operations: same-cycle grant and writeback latency.
        wb_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (tv[i].who) begin
                op1_a = tv[i].a; op1_b = tv[i].b; dest1 = tv[i].d; exp1 = tv[i].p; req1 = 1'b1;
            end else begin
                op0_a = tv[i].a; op0_b = tv[i].b; dest0 = tv[i].d; exp0 = tv[i].p; req0 = 1'b1;
            end
            @(negedge clk);
            chk("tv_gnt", {gnt0, gnt1}, tv[i].who ? 2'b01 : 2'b10);
            @(posedge clk);
            #1;
            req0 = 1'b0;
            req1 = 1'b0;
            k = 0;
            while (k < 10) begin
                @(negedge clk);
                k++;
                if (wb_valid) break;
            end
            chk("tv_latency", k, 4);
            cyc();
        end
        drain("tv");

        op0_a = 32'h3FC00000; op0_b = 32'h40000000; exp0 = 32'h40400000;
        op1_a = 32'h40000000; op1_b = 32'h40000000; exp1 = 32'h40800000;

        // Both requesters held: grants alternate starting with requester 0.
        dest0 = 4'd0; dest1 = 4'd1;
        glog.delete();
        req0 = 1'b1; req1 = 1'b1;
        n = 0;
        while (glog.size() < 8 && n < 40) begin
            step();
            n++;
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_count", glog.size() >= 8, 1);
        for (int i = 0; i < 8 && i < glog.size(); i++) chk("rr_order", glog[i], i % 2);
        drain("rr");

        // Credit limit with writeback stalled, then pop and grant together.
        dest0 = 4'd0;
        base = ngnt;
        wb_ready = 1'b0;
        req0 = 1'b1;
        repeat (12) step();
        chk("credit_limit", ngnt - base, 4);
        chk("fifo_full_valid", swv, 1);
        wb_ready = 1'b1;
        step();
        chk("pop_and_grant", {sg0, swv}, 2'b11);
        wb_ready = 1'b0;
        step();
        chk("outstanding_kept", sg0, 0);
        wb_ready = 1'b1;
        n = 0;
        while (ngnt - base < 6 && n < 20) begin
            step();
            n++;
        end
        req0 = 1'b0;
        chk("credit_all_granted", ngnt - base, 6);
        drain("credit");

        // Same destination tag from both requesters.
        wb_ready = 1'b1;
        dest0 = 4'd5;
        req0 = 1'b1;
        step();
        chk("tag_first_gnt", sg0, 1);
        req0 = 1'b0;
        dest1 = 4'd5;
        req1 = 1'b1;
`ifdef MUL_SCHED_SCOREBOARD_EN
        n = 0;
        popped = 1'b0;
        while (n < 20 && !popped) begin
            @(negedge clk);
            chk("sb_block", gnt1, 0);
            chk("sb_mask", busy_mask, 16'h0020);
            if (wb_valid && wb_dest == 4'd5) popped = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk("sb_popped", popped, 1);
        step();
        chk("sb_release", sg1, 1);
`else
        step();
        chk("nosb_gnt1", sg1, 1);
        chk("nosb_mask", busy_mask, 0);
`endif
        req1 = 1'b0;
        drain("tag");

        // Reset with one buffered result and two operations in flight.
        dest0 = 4'd2;
        wb_ready = 1'b0;
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        repeat (5) step();
        chk("pre_rst_valid", wb_valid, 1);
        req0 = 1'b1;
        step();
        step();
        req0 = 1'b0;
        nrst = 1'b0;
        req0 = 1'b1;
        #1;
        chk("rst_mid_valid", wb_valid, 0);
        chk("rst_mid_mask", busy_mask, 0);
        chk("rst_mid_gnt", {gnt0, gnt1, mulEna}, 0);
        chk("rst_mid_data", {wb_data, wb_dest, operand1, operand2, in_dest}, 0);
        sbq.delete();
        req0 = 1'b0;
        cyc();
        nrst = 1'b1;
        wb_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (wb_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("rst_no_stale_wb", seen, 0);

        // Pointer back to requester 0 after reset.
        dest0 = 4'd0; dest1 = 4'd1;
        req0 = 1'b1; req1 = 1'b1;
        step();
        chk("rst_rr_pref0", {sg0, sg1}, 2'b10);
        req0 = 1'b0; req1 = 1'b0;
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
